// File: rtl/modn_counter_param.sv
// Parametrised mod-N up/down counter with synchronous clear/load, wrap or
// saturate at the terminal value, and a terminal-count flag for cascading.
module modn_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0,
    parameter bit WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             roll,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable in the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("modn_counter_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("modn_counter_param: RESET_VAL must be in 0..MODULUS-1");
        end
    endgenerate

    logic at_top;
    logic at_zero;
    logic load_ok;

    assign at_top  = (count == TOP);
    assign at_zero = (count == '0);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // tc ignores en so a chain can use en_next = en & tc with no added latency.
    assign tc = up_dn ? at_top : at_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= RST_CNT;
            roll     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            roll     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                if (load_ok) count    <= load_val;
                else         load_err <= 1'b1;
            end else if (en) begin
                if (up_dn) begin
                    if (at_top) begin
                        roll <= 1'b1;
                        if (WRAP) count <= '0;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    if (at_zero) begin
                        roll <= 1'b1;
                        if (WRAP) count <= TOP;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_modn_counter_param.sv
// Self-checking bench: a wrapping and a saturating mod-10 counter plus a
// full-range mod-8 counter, with expected results queued per step.
module tb_modn_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [2:0] lv3 = '0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;

    logic [3:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;
    logic       tc_a, roll_a, lerr_a;
    logic       tc_b, roll_b, lerr_b;
    logic       tc_c, roll_c, lerr_c;

    typedef struct {
        logic [3:0] cnt;
        logic       roll;
        logic       lerr;
        logic       tc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    int nrun = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    modn_counter_param #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_a), .tc(tc_a), .roll(roll_a), .load_err(lerr_a));

    modn_counter_param #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_b), .tc(tc_b), .roll(roll_b), .load_err(lerr_b));

    modn_counter_param #(.WIDTH(3), .MODULUS(8), .RESET_VAL(6), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv3),
        .en(en), .up_dn(up_dn), .count(cnt_c), .tc(tc_c), .roll(roll_c), .load_err(lerr_c));

    task automatic set_in(input logic c, input logic l, input logic [3:0] lv,
                          input logic e, input logic u);
        @(negedge clk);
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
    endtask

    task automatic test_reset;
        set_in(0, 0, 4'd0, 1, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        nrun++;
        if (cnt_a !== 4'd0 || roll_a !== 1'b0 || lerr_a !== 1'b0 || cnt_c !== 3'd6) begin
            nfail++;
            $display("FAIL reset_async: got a=%0d roll=%b lerr=%b c=%0d, want a=0 roll=0 lerr=0 c=6",
                     cnt_a, roll_a, lerr_a, cnt_c);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            nrun++;
            if (cnt_a !== 4'd0 || roll_a !== 1'b0 || lerr_a !== 1'b0 || cnt_c !== 3'd6) begin
                nfail++;
                $display("FAIL reset_hold[%0d]: got a=%0d roll=%b lerr=%b c=%0d, want a=0 roll=0 lerr=0 c=6",
                         i, cnt_a, roll_a, lerr_a, cnt_c);
            end
        end
        set_in(0, 0, 4'd0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic test_up_wrap;
        for (int i = 0; i < 12; i++) begin
            set_in(0, 0, 4'd0, 1, 1);
            qa.push_back('{cnt: 4'((i + 1) % 10), roll: ((i + 1) % 10 == 0),
                           lerr: 1'b0, tc: ((i + 1) % 10 == 9)});
            @(posedge clk); #1;
            ea = qa.pop_front();
            nrun++;
            if (cnt_a !== ea.cnt || roll_a !== ea.roll || lerr_a !== ea.lerr || tc_a !== ea.tc) begin
                nfail++;
                $display("FAIL up_wrap[%0d]: got cnt=%0d roll=%b lerr=%b tc=%b, want cnt=%0d roll=%b lerr=%b tc=%b",
                         i, cnt_a, roll_a, lerr_a, tc_a, ea.cnt, ea.roll, ea.lerr, ea.tc);
            end
        end
    endtask

    task automatic test_down_wrap_sat;
        set_in(0, 1, 4'd0, 0, 0);
        qa.push_back('{cnt: 4'd0, roll: 1'b0, lerr: 1'b0, tc: 1'b1});
        qb.push_back('{cnt: 4'd0, roll: 1'b0, lerr: 1'b0, tc: 1'b1});
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                ea = qa.pop_front(); eb = qb.pop_front();
            end else begin
                set_in(0, 0, 4'd0, 1, 0);
                // wrapping instance: 9, 8, ...; saturating instance holds 0 and pulses every cycle
                qa.push_back('{cnt: 4'(10 - i), roll: (i == 1), lerr: 1'b0, tc: 1'b0});
                qb.push_back('{cnt: 4'd0, roll: 1'b1, lerr: 1'b0, tc: 1'b1});
                @(posedge clk); #1;
                ea = qa.pop_front(); eb = qb.pop_front();
            end
            nrun++;
            if (cnt_a !== ea.cnt || roll_a !== ea.roll || tc_a !== ea.tc) begin
                nfail++;
                $display("FAIL down_wrap[%0d]: got cnt=%0d roll=%b tc=%b, want cnt=%0d roll=%b tc=%b",
                         i, cnt_a, roll_a, tc_a, ea.cnt, ea.roll, ea.tc);
            end
            nrun++;
            if (cnt_b !== eb.cnt || roll_b !== eb.roll || tc_b !== eb.tc) begin
                nfail++;
                $display("FAIL down_sat[%0d]: got cnt=%0d roll=%b tc=%b, want cnt=%0d roll=%b tc=%b",
                         i, cnt_b, roll_b, tc_b, eb.cnt, eb.roll, eb.tc);
            end
        end
        // saturating instance at the top going up also holds and pulses
        set_in(0, 1, 4'd9, 0, 1);
        @(posedge clk);
        set_in(0, 0, 4'd0, 1, 1);
        qb.push_back('{cnt: 4'd9, roll: 1'b1, lerr: 1'b0, tc: 1'b1});
        @(posedge clk); #1;
        eb = qb.pop_front();
        nrun++;
        if (cnt_b !== eb.cnt || roll_b !== eb.roll || tc_b !== eb.tc) begin
            nfail++;
            $display("FAIL up_sat: got cnt=%0d roll=%b tc=%b, want cnt=%0d roll=%b tc=%b",
                     cnt_b, roll_b, tc_b, eb.cnt, eb.roll, eb.tc);
        end
    endtask

    task automatic test_load_range;
        logic [3:0] lvs [3] = '{4'd7, 4'd12, 4'd0};
        logic       lds [3] = '{1'b1, 1'b1, 1'b0};
        logic       errs[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_in(0, lds[i], lvs[i], 0, 1);
            qa.push_back('{cnt: 4'd7, roll: 1'b0, lerr: errs[i], tc: 1'b0});
            @(posedge clk); #1;
            ea = qa.pop_front();
            nrun++;
            if (cnt_a !== ea.cnt || lerr_a !== ea.lerr || roll_a !== ea.roll) begin
                nfail++;
                $display("FAIL load_range[%0d]: got cnt=%0d lerr=%b roll=%b, want cnt=%0d lerr=%b roll=%b",
                         i, cnt_a, lerr_a, roll_a, ea.cnt, ea.lerr, ea.roll);
            end
        end
        // 15 is the largest out-of-range code for a 4-bit mod-10 count
        set_in(0, 1, 4'd15, 0, 1);
        @(posedge clk); #1;
        nrun++;
        if (cnt_a !== 4'd7 || lerr_a !== 1'b1) begin
            nfail++;
            $display("FAIL load_max: got cnt=%0d lerr=%b, want cnt=7 lerr=1", cnt_a, lerr_a);
        end
    endtask

    task automatic test_priority;
        set_in(1, 1, 4'd5, 1, 1);
        qa.push_back('{cnt: 4'd0, roll: 1'b0, lerr: 1'b0, tc: 1'b0});
        @(posedge clk); #1;
        ea = qa.pop_front();
        nrun++;
        if (cnt_a !== ea.cnt || roll_a !== ea.roll || lerr_a !== ea.lerr) begin
            nfail++;
            $display("FAIL prio_clr: got cnt=%0d roll=%b lerr=%b, want cnt=%0d roll=0 lerr=0",
                     cnt_a, roll_a, lerr_a, ea.cnt);
        end
        set_in(0, 1, 4'd5, 1, 1);
        qa.push_back('{cnt: 4'd5, roll: 1'b0, lerr: 1'b0, tc: 1'b0});
        @(posedge clk); #1;
        ea = qa.pop_front();
        nrun++;
        if (cnt_a !== ea.cnt || roll_a !== ea.roll) begin
            nfail++;
            $display("FAIL prio_load: got cnt=%0d roll=%b, want cnt=%0d roll=0", cnt_a, roll_a, ea.cnt);
        end
    endtask

    task automatic test_back_to_back;
        // direction flips on consecutive enabled edges, starting from 5
        logic       dirs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] exps[4] = '{4'd4, 4'd5, 4'd6, 4'd5};
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 4'd0, 1, dirs[i]);
            qa.push_back('{cnt: exps[i], roll: 1'b0, lerr: 1'b0, tc: 1'b0});
            @(posedge clk); #1;
            ea = qa.pop_front();
            nrun++;
            if (cnt_a !== ea.cnt || roll_a !== ea.roll || tc_a !== ea.tc) begin
                nfail++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d roll=%b tc=%b, want cnt=%0d roll=0 tc=0",
                         i, cnt_a, roll_a, tc_a, ea.cnt);
            end
        end
        set_in(0, 0, 4'd0, 0, 1);
    endtask

    task automatic test_full_range;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 4'd0, 1, 1);
            qc.push_back('{cnt: 4'((7 + i) % 8), roll: (i == 1), lerr: 1'b0, tc: (i == 0)});
            @(posedge clk); #1;
            ec = qc.pop_front();
            nrun++;
            if (cnt_c !== ec.cnt[2:0] || roll_c !== ec.roll || tc_c !== ec.tc || lerr_c !== ec.lerr) begin
                nfail++;
                $display("FAIL full_range[%0d]: got cnt=%0d roll=%b tc=%b lerr=%b, want cnt=%0d roll=%b tc=%b lerr=0",
                         i, cnt_c, roll_c, tc_c, lerr_c, ec.cnt, ec.roll, ec.tc);
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        nrun++;
        if (cnt_c !== 3'd6 || roll_c !== 1'b0) begin
            nfail++;
            $display("FAIL full_range_rst: got cnt=%0d roll=%b, want cnt=6 roll=0", cnt_c, roll_c);
        end
        set_in(0, 0, 4'd0, 0, 1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap_sat();
        test_load_range();
        test_priority();
        test_back_to_back();
        test_full_range();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
